// File: rtl/div_param.sv
// div_param: multi-cycle restoring divider (IDLE/RUN/FIX), WIDTH-bit
// operands, signed by default; unsigned mode selectable per start.
//
// Optional feature macro: DIV_PARAM_UNSIGNED_EN
//   defined   -> DivSigned port exists (1 = signed div, 0 = unsigned divu)
//   undefined -> no DivSigned port, every division is signed
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   DivCtrl    start request, sampled only in IDLE
//   DivSigned  signed/unsigned select (only with DIV_PARAM_UNSIGNED_EN)
//   dividendo  dividend, sampled at start
//   divisor    divisor, sampled at start
//   busy       high while in RUN or FIX
//   divOut     one-cycle pulse: HI/LO were just updated
//   divZero    one-cycle pulse: start rejected, divisor was zero
//   HI         remainder register
//   LO         quotient register
module div_param #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DivCtrl,
`ifdef DIV_PARAM_UNSIGNED_EN
    input  logic             DivSigned,
`endif
    input  logic [WIDTH-1:0] dividendo,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             divOut,
    output logic             divZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_out;
    logic             r_div_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_abs;
    logic [WIDTH-1:0] w_b_abs;
    logic             w_b_zero;
    logic             w_busy;
    logic             w_start;
    logic             w_reject;
    logic             w_last;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

`ifdef DIV_PARAM_UNSIGNED_EN
    assign w_signed = DivSigned;
`else
    assign w_signed = 1'b1;
`endif

    // Magnitudes; the most-negative value maps onto itself, which is
    // the correct unsigned magnitude 2^(WIDTH-1).
    assign w_a_neg  = w_signed & dividendo[WIDTH-1];
    assign w_b_neg  = w_signed & divisor[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -dividendo : dividendo;
    assign w_b_abs  = w_b_neg ? -divisor : divisor;
    assign w_b_zero = (divisor == '0);

    assign w_last = (r_count == CW'(WIDTH - 1));

    // One restoring step. The shifted remainder needs WIDTH+1 bits;
    // when its top bit is set it is certainly >= the divisor, and the
    // true difference is < divisor, so a WIDTH-bit subtract is exact.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= r_dvs);
    assign w_rem_next = w_ge ? (w_shift[WIDTH-1:0] - r_dvs)
                             : w_shift[WIDTH-1:0];
    assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_busy   = 1'b0;
        w_start  = 1'b0;
        w_reject = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (DivCtrl) begin
                    if (w_b_zero) begin
                        w_reject = 1'b1;
                    end else begin
                        w_start = 1'b1;
                        w_next  = RUN;
                    end
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = FIX;
                end
            end
            FIX: begin
                w_busy = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_dvs      <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_out  <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_div_out  <= 1'b0;
            r_div_zero <= w_reject;
            if (w_start) begin
                // r_quo starts as the dividend; its MSBs shift out into
                // the remainder while quotient bits shift in at the LSB.
                r_quo   <= w_a_abs;
                r_dvs   <= w_b_abs;
                r_rem   <= '0;
                r_count <= '0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end
            if (r_state == RUN) begin
                r_rem   <= w_rem_next;
                r_quo   <= w_quo_next;
                r_count <= r_count + CW'(1);
            end
            if (r_state == FIX) begin
                r_lo      <= r_neg_q ? -r_quo : r_quo;
                r_hi      <= r_neg_r ? -r_rem : r_rem;
                r_div_out <= 1'b1;
            end
        end
    end

    assign busy    = w_busy;
    assign divOut  = r_div_out;
    assign divZero = r_div_zero;
    assign HI      = r_hi;
    assign LO      = r_lo;

endmodule

// File: doc/div_param.md
DIV_PARAM -- requirements
Module: div_param

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  sole clock; every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 DivCtrl  input  1  start request, sampled only in IDLE.
REQ-005 DivSigned  input  1  1 = signed (div), 0 = unsigned (divu); this port exists only when DIV_PARAM_UNSIGNED_EN is defined.
REQ-006 dividendo  input  WIDTH  dividend, sampled at start.
REQ-007 divisor  input  WIDTH  divisor, sampled at start.
REQ-008 busy  output  1  high while in RUN or FIX.
REQ-009 divOut  output  1  one-cycle pulse marking that HI/LO have just been updated.
REQ-010 divZero  output  1  one-cycle pulse marking a start that was rejected because divisor == 0.
REQ-011 HI  output  WIDTH  remainder register.
REQ-012 LO  output  WIDTH  quotient register.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and FIX.
REQ-014 IDLE, DivCtrl=1, divisor!=0: latch |dividendo|, |divisor| and both sign bits (signs forced to 0 in unsigned mode); clear the partial remainder and count; go to RUN.
REQ-015 IDLE, DivCtrl=1, divisor==0: assert divZero for one cycle, stay in IDLE, leave HI/LO unchanged, keep divOut low.
REQ-016 RUN: one restoring step per cycle, shift remainder left by one and bring in the next dividend MSB; if the remainder is >= the divisor, subtract and set the quotient bit to 1.
REQ-017 RUN SHALL last exactly WIDTH cycles, counted by a $clog2(WIDTH+1)-bit counter, then go to FIX.
REQ-018 FIX: LO = quotient, negated if the operand signs differ; HI = remainder, negated if the dividend was negative; assert divOut for one cycle; return to IDLE.
REQ-019 Latency: start sampled at edge k gives HI/LO valid and divOut=1 after edge k+WIDTH+1; throughput is one division per WIDTH+2 cycles.
REQ-020 Signed semantics: the quotient truncates toward zero and the remainder takes the dividend's sign.
REQ-021 Most-negative value divided by -1: LO = most-negative value (WIDTH-bit wrap) and HI = 0, with no flag raised.
REQ-022 All arithmetic is performed in WIDTH bits, except the remainder path, which is WIDTH+1 bits to hold the compare/subtract carry.
REQ-023 DivCtrl is ignored while busy=1, and operand changes during RUN/FIX have no effect.
REQ-024 HI/LO SHALL hold their last value until the next FIX or reset.
REQ-025 divOut and divZero SHALL never be high in the same cycle.

Reset
REQ-026 Reset SHALL force the state to IDLE and clear count, quotient and remainder.
REQ-027 Reset SHALL clear HI=0, LO=0, busy=0, divOut=0, divZero=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no divOut pulse; reset has priority over DivCtrl in the same cycle.

Configuration
REQ-029 Macro DIV_PARAM_UNSIGNED_EN defined: the DivSigned port exists and selects signed or unsigned operation per start.
REQ-030 DIV_PARAM_UNSIGNED_EN undefined: no DivSigned port, all operations are signed, and behaviour is otherwise identical.

Verification (WIDTH=32 unless noted)
REQ-031 dividendo=7, divisor=2, signed, start at edge 0 -> busy for 33 cycles; divOut=1 after edge 33 with LO=3, HI=1.
REQ-032 dividendo=0xFFFFFFF9 (-7), divisor=2, signed -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; dividendo=7, divisor=0xFFFFFFFE -> LO=0xFFFFFFFD, HI=1.
REQ-033 dividendo=0x80000000, divisor=0xFFFFFFFF, signed -> LO=0x80000000, HI=0; with macro defined and DivSigned=0 -> LO=0, HI=0x80000000.
REQ-034 divisor=0 with DivCtrl=1 -> divZero pulses one cycle, busy stays 0, HI/LO keep their prior values, no divOut.
REQ-035 Reset asserted at RUN cycle 10 -> next cycle state=IDLE, HI=LO=0, no divOut; a fresh 100/7 then gives LO=14, HI=2.
REQ-036 WIDTH=8: dividendo=0xFF, divisor=0x10, DivSigned=0 -> LO=0x0F, HI=0x0F, divOut after edge 9.
